// File: rtl/mycpu_store_unit_pkg.sv
// Constants and types shared by the myCPU memory stage.
// The writeback load extractor uses the same Mode-field encoding.
package mycpu_store_unit_pkg;

  localparam int MODE_LOAD  = 5;
  localparam int MODE_STORE = 4;

  localparam logic [2:0] SZ_B = 3'b000;
  localparam logic [2:0] SZ_H = 3'b001;
  localparam logic [2:0] SZ_W = 3'b010;
  localparam logic [2:0] SZ_L = 3'b011;
  localparam logic [2:0] SZ_R = 3'b100;

  // One store-buffer slot: the word address plus the lane-aligned write.
  typedef struct packed {
    logic [29:0] waddr;
    logic [3:0]  wen;
    logic [31:0] wdata;
  } sb_entry_t;

  // Size codes 101-111 are reserved and behave as a no-op store.
  function automatic logic size_valid(input logic [2:0] sz);
    return sz inside {SZ_B, SZ_H, SZ_W, SZ_L, SZ_R};
  endfunction

endpackage

// File: rtl/mycpu_store_unit_if.sv
// Store-unit bus bundle: MEM-stage store port, data-SRAM write port and load hazard probe.
interface mycpu_store_unit_if;

  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_mode;
  logic [31:0] in_addr;
  logic [31:0] in_data;

  logic        data_sram_en;
  logic        data_sram_ready;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;

  logic [31:0] ld_addr;
  logic        ld_hazard;

  logic        ades;
  logic [31:0] badvaddr;
  logic        sb_empty;

  // The environment (pipeline + SRAM) drives the master side.
  modport master (
    output in_valid, in_mode, in_addr, in_data, data_sram_ready, ld_addr,
    input  in_ready, data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
           ld_hazard, ades, badvaddr, sb_empty
  );

  modport slave (
    input  in_valid, in_mode, in_addr, in_data, data_sram_ready, ld_addr,
    output in_ready, data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
           ld_hazard, ades, badvaddr, sb_empty
  );

endinterface

// File: rtl/mycpu_store_lanes.sv
// Combinational store lane generator: byte enables, aligned write data and
// misalignment flag for a little-endian store of the given size at byte offset a.
module mycpu_store_lanes
  import mycpu_store_unit_pkg::*;
(
  input  logic [2:0]  size_i,
  input  logic [1:0]  a_i,
  input  logic [31:0] rt_i,
  output logic [3:0]  wen_o,
  output logic [31:0] wdata_o,
  output logic        misaligned_o
);

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    wen_o        = 4'b0000;
    wdata_o      = 32'h0;
    misaligned_o = 1'b0;
    case (size_i)
      SZ_B: begin
        wen_o   = 4'b0001 << a_i;
        wdata_o = {4{rt_i[7:0]}};
      end
      SZ_H: begin
        wen_o        = a_i[1] ? 4'b1100 : 4'b0011;
        wdata_o      = {2{rt_i[15:0]}};
        misaligned_o = a_i[0];
      end
      SZ_W: begin
        wen_o        = 4'b1111;
        wdata_o      = rt_i;
        misaligned_o = (a_i != 2'b00);
      end
      // SWL writes the high-order bytes of rt into the low lanes up to a.
      SZ_L: begin
        case (a_i)
          2'd0:    begin wen_o = 4'b0001; wdata_o = {24'h0, rt_i[31:24]}; end
          2'd1:    begin wen_o = 4'b0011; wdata_o = {16'h0, rt_i[31:16]}; end
          2'd2:    begin wen_o = 4'b0111; wdata_o = {8'h0,  rt_i[31:8]};  end
          default: begin wen_o = 4'b1111; wdata_o = rt_i;                 end
        endcase
      end
      SZ_R: begin
        case (a_i)
          2'd0:    begin wen_o = 4'b1111; wdata_o = rt_i;                 end
          2'd1:    begin wen_o = 4'b1110; wdata_o = {rt_i[23:0], 8'h0};   end
          2'd2:    begin wen_o = 4'b1100; wdata_o = {rt_i[15:0], 16'h0};  end
          default: begin wen_o = 4'b1000; wdata_o = {rt_i[7:0], 24'h0};   end
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mycpu_store_unit.sv
// Memory-stage store path: lane generation, FIFO store buffer draining to the
// data SRAM, load word-address hazard check and store address-error capture.
module mycpu_store_unit
  import mycpu_store_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  mycpu_store_unit_if.slave bus
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  typedef logic [AW:0] ptr_t;

  ptr_t        wr_ptr_q, wr_ptr_d;
  ptr_t        rd_ptr_q, rd_ptr_d;
  ptr_t        count;
  logic        empty;
  sb_entry_t   mem_q [DEPTH];
  sb_entry_t   head;

  logic        ades_q, ades_d;
  logic [31:0] badvaddr_q, badvaddr_d;

  logic [3:0]  lane_wen;
  logic [31:0] lane_wdata;
  logic        lane_mis;
  logic        accept, is_store, push, pop;

  mycpu_store_lanes u_lanes (
    .size_i       (bus.in_mode[3:1]),
    .a_i          (bus.in_addr[1:0]),
    .rt_i         (bus.in_data),
    .wen_o        (lane_wen),
    .wdata_o      (lane_wdata),
    .misaligned_o (lane_mis)
  );

  // Load flag, sign-extend flag and the load byte offset play no part in the store path.
  logic unused_bits;
  assign unused_bits = ^{bus.in_mode[MODE_LOAD], bus.in_mode[0], bus.ld_addr[1:0]};

  assign count    = wr_ptr_q - rd_ptr_q;
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign accept   = bus.in_valid && bus.in_ready;
  assign is_store = bus.in_mode[MODE_STORE] && size_valid(bus.in_mode[3:1]);
  assign push     = accept && is_store && !lane_mis;
  assign pop      = !empty && bus.data_sram_ready;

  always_comb begin
    wr_ptr_d   = wr_ptr_q + ptr_t'(push);
    rd_ptr_d   = rd_ptr_q + ptr_t'(pop);
    ades_d     = accept && is_store && lane_mis;
    badvaddr_d = ades_d ? bus.in_addr : badvaddr_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ades_q     <= 1'b0;
      badvaddr_q <= 32'h0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ades_q     <= ades_d;
      badvaddr_q <= badvaddr_d;
    end
  end

  // NOTE: the storage array has no reset; validity comes from the pointers and outputs are gated by empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= '{waddr: bus.in_addr[31:2], wen: lane_wen, wdata: lane_wdata};
    end
  end

  // A slot is valid when its distance from the read pointer is below the registered count.
  always_comb begin
    bus.ld_hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (({1'b0, AW'(i) - rd_ptr_q[AW-1:0]} < count) &&
          (mem_q[i].waddr == bus.ld_addr[31:2])) begin
        bus.ld_hazard = 1'b1;
      end
    end
  end

  assign head = mem_q[rd_ptr_q[AW-1:0]];

  assign bus.in_ready        = (count < DEPTH_C);
  assign bus.sb_empty        = empty;
  assign bus.data_sram_en    = !empty;
  assign bus.data_sram_wen   = empty ? 4'b0000 : head.wen;
  assign bus.data_sram_addr  = empty ? 32'h0   : {head.waddr, 2'b00};
  assign bus.data_sram_wdata = empty ? 32'h0   : head.wdata;
  assign bus.ades            = ades_q;
  assign bus.badvaddr        = badvaddr_q;

endmodule

// File: tb/tb_mycpu_store_unit.sv
// Directed bench for mycpu_store_unit: scoreboard of expected SRAM writes popped on each handshake.
module tb_mycpu_store_unit;

  localparam logic [5:0] M_SB  = 6'h10;
  localparam logic [5:0] M_SH  = 6'h12;
  localparam logic [5:0] M_SW  = 6'h14;
  localparam logic [5:0] M_SWL = 6'h16;
  localparam logic [5:0] M_SWR = 6'h18;
  localparam logic [5:0] M_LW  = 6'h24;
  localparam logic [5:0] M_BAD = 6'h1A;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  wen;
    logic [31:0] wdata;
  } exp_t;

  logic clk;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  exp_t sb_q[$];

  mycpu_store_unit_if bus ();

  mycpu_store_unit #(.DEPTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [5:0] mode, input logic [31:0] addr, input logic [31:0] data,
                      input logic push, input logic [3:0] wen, input logic [31:0] wdata);
    int n;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      step();
      n++;
    end
    check("send_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_mode  = mode;
    bus.in_addr  = addr;
    bus.in_data  = data;
    if (push) sb_q.push_back('{{addr[31:2], 2'b00}, wen, wdata});
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (!bus.sb_empty && n < 50) begin
      step();
      n++;
    end
    check("drain_done", 32'(bus.sb_empty), 32'd1);
  endtask

  // Every SRAM handshake must match the oldest outstanding expected write.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset && bus.data_sram_en && bus.data_sram_ready) begin
      check("write_expected", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("sram_addr",  bus.data_sram_addr,       e.addr);
        check("sram_wen",   32'(bus.data_sram_wen),   32'(e.wen));
        check("sram_wdata", bus.data_sram_wdata,      e.wdata);
      end
    end
  end

  initial begin
    reset               = 1'b0;
    bus.in_valid        = 1'b0;
    bus.in_mode         = 6'h0;
    bus.in_addr         = 32'h0;
    bus.in_data         = 32'h0;
    bus.data_sram_ready = 1'b1;
    bus.ld_addr         = 32'h0;
    #1 reset = 1'b1;
    #2;
    check("rst_en",       32'(bus.data_sram_en),  32'd0);
    check("rst_empty",    32'(bus.sb_empty),      32'd1);
    check("rst_in_ready", 32'(bus.in_ready),      32'd1);
    check("rst_ades",     32'(bus.ades),          32'd0);
    check("rst_badvaddr", bus.badvaddr,           32'h0);
    check("rst_hazard",   32'(bus.ld_hazard),     32'd0);
    check("rst_wen",      32'(bus.data_sram_wen), 32'd0);
    check("rst_addr",     bus.data_sram_addr,     32'h0);
    check("rst_wdata",    bus.data_sram_wdata,    32'h0);
    step();
    reset = 1'b0;

    // SB at offset 3: no pass-through, visible next cycle, drained after.
    step();
    bus.in_valid = 1'b1;
    bus.in_mode  = M_SB;
    bus.in_addr  = 32'h0000_1003;
    bus.in_data  = 32'h1234_5678;
    sb_q.push_back('{32'h0000_1000, 4'b1000, 32'h7878_7878});
    #1 check("no_passthrough", 32'(bus.data_sram_en), 32'd0);
    step();
    bus.in_valid = 1'b0;
    check("sb_visible", 32'(bus.data_sram_en), 32'd1);
    step();
    check("sb_drained", 32'(bus.sb_empty), 32'd1);

    // Lane patterns, back to back with the SRAM always ready.
    send(M_SWL, 32'h0000_1001, 32'hAABB_CCDD, 1'b1, 4'b0011, 32'h0000_AABB);
    send(M_SWR, 32'h0000_1001, 32'hAABB_CCDD, 1'b1, 4'b1110, 32'hBBCC_DD00);
    send(M_SH,  32'h0000_1002, 32'h0000_BEEF, 1'b1, 4'b1100, 32'hBEEF_BEEF);
    send(M_SWL, 32'h0000_1003, 32'h1122_3344, 1'b1, 4'b1111, 32'h1122_3344);
    send(M_SWR, 32'h0000_1003, 32'h1122_3344, 1'b1, 4'b1000, 32'h4400_0000);
    send(M_SW,  32'h0000_1004, 32'hCAFE_F00D, 1'b1, 4'b1111, 32'hCAFE_F00D);
    send(M_SB,  32'h0000_1005, 32'h0000_009A, 1'b1, 4'b0010, 32'h9A9A_9A9A);
    wait_empty();

    // Address errors.
    send(M_SW, 32'h0000_2002, 32'h1, 1'b0, 4'b0, 32'h0);
    check("sw_ades",     32'(bus.ades),         32'd1);
    check("sw_badvaddr", bus.badvaddr,          32'h0000_2002);
    check("sw_no_write", 32'(bus.data_sram_en), 32'd0);
    step();
    check("ades_pulse",  32'(bus.ades),         32'd0);
    check("badv_held",   bus.badvaddr,          32'h0000_2002);
    send(M_SH, 32'h0000_2001, 32'h2, 1'b0, 4'b0, 32'h0);
    check("sh_ades",     32'(bus.ades),         32'd1);
    check("sh_badvaddr", bus.badvaddr,          32'h0000_2001);
    send(M_LW, 32'h0000_2003, 32'h3, 1'b0, 4'b0, 32'h0);
    check("load_no_ades", 32'(bus.ades),        32'd0);
    check("load_badv",    bus.badvaddr,         32'h0000_2001);
    send(M_BAD, 32'h0000_2003, 32'h4, 1'b0, 4'b0, 32'h0);
    check("nop_no_ades", 32'(bus.ades),         32'd0);
    check("nop_no_push", 32'(bus.sb_empty),     32'd1);

    // Back-pressure: fill the buffer, hold the head, then drain in order.
    bus.data_sram_ready = 1'b0;
    send(M_SW, 32'h0000_4000, 32'hA0A0_A0A0, 1'b1, 4'b1111, 32'hA0A0_A0A0);
    send(M_SH, 32'h0000_4006, 32'h0000_B1B1, 1'b1, 4'b1100, 32'hB1B1_B1B1);
    check("full_not_ready", 32'(bus.in_ready),     32'd0);
    check("full_en",        32'(bus.data_sram_en), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_mode  = M_SB;
    bus.in_addr  = 32'h0000_4009;
    bus.in_data  = 32'h0000_00C3;
    sb_q.push_back('{32'h0000_4008, 4'b0010, 32'hC3C3_C3C3});
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_wen",   32'(bus.data_sram_wen), 32'hF);
      check("hold_addr",  bus.data_sram_addr,     32'h0000_4000);
      check("hold_wdata", bus.data_sram_wdata,    32'hA0A0_A0A0);
      check("hold_ready", 32'(bus.in_ready),      32'd0);
    end
    bus.data_sram_ready = 1'b1;
    step();
    check("ready_after_pop", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    check("third_head_wen",  32'(bus.data_sram_wen), 32'h2);
    check("third_head_addr", bus.data_sram_addr,     32'h0000_4008);
    wait_empty();

    // Load hazard against a buffered word store.
    bus.data_sram_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_mode  = M_SW;
    bus.in_addr  = 32'h0000_3004;
    bus.in_data  = 32'h0000_0055;
    bus.ld_addr  = 32'h0000_3004;
    sb_q.push_back('{32'h0000_3004, 4'b1111, 32'h0000_0055});
    #1 check("hz_push_same_cycle", 32'(bus.ld_hazard), 32'd0);
    step();
    bus.in_valid = 1'b0;
    bus.ld_addr  = 32'h0000_3006;
    #1 check("hz_match",  32'(bus.ld_hazard), 32'd1);
    bus.ld_addr  = 32'h0000_3008;
    #1 check("hz_other",  32'(bus.ld_hazard), 32'd0);
    bus.ld_addr  = 32'h0000_3006;
    bus.data_sram_ready = 1'b1;
    #1 check("hz_popping", 32'(bus.ld_hazard), 32'd1);
    wait_empty();
    check("hz_drained", 32'(bus.ld_hazard), 32'd0);

    // Reset with two queued stores: they are lost and never written.
    bus.data_sram_ready = 1'b0;
    send(M_SW, 32'h0000_5000, 32'h0000_0001, 1'b1, 4'b1111, 32'h0000_0001);
    send(M_SW, 32'h0000_5004, 32'h0000_0002, 1'b1, 4'b1111, 32'h0000_0002);
    check("pre_rst_en",    32'(bus.data_sram_en), 32'd1);
    check("pre_rst_ready", 32'(bus.in_ready),     32'd0);
    reset = 1'b1;
    #1;
    check("mid_rst_en",    32'(bus.data_sram_en),  32'd0);
    check("mid_rst_ready", 32'(bus.in_ready),      32'd1);
    check("mid_rst_empty", 32'(bus.sb_empty),      32'd1);
    check("mid_rst_wen",   32'(bus.data_sram_wen), 32'd0);
    sb_q.delete();
    bus.data_sram_ready = 1'b1;
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("post_rst_empty", 32'(bus.sb_empty), 32'd1);
    check("scoreboard_left", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mycpu_store_unit.md
# mycpu_store_unit

Memory-stage store path of the myCPU pipeline and the write-side counterpart of the writeback load extractor. It turns a store micro-op (address, rt data, 6-bit Mode) into data-SRAM byte enables and lane-aligned write data, and detects store address errors. Accepted stores are queued in a small FIFO store buffer that drains to the data SRAM under a valid/ready handshake. A word-address hazard check lets younger loads stall until matching stores have drained.

## Interface
Parameters:
- DEPTH, 2: store-buffer entries; power of two, ≥2.

Ports:
- clk  in  1  clock. One clock domain; reset is asynchronous and active-high.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  store micro-op presented by the MEM stage.
- in_ready  out  1  unit can accept this cycle; equals count < DEPTH.
- in_mode  in  6  Mode field:
  - [5] load;
  - [4] store;
  - [3:1] size: 000 byte, 001 half, 010 word, 011 SWL, 100 SWR;
  - [0] sign extend (ignored here).
- in_addr  in  32  byte address.
- in_data  in  32  rt value.
- data_sram_en  out  1  write request valid; equals !empty.
- data_sram_ready  in  1  SRAM accepts the head entry this cycle.
- data_sram_wen  out  4  byte enables of the head entry.
- data_sram_addr  out  32  {head_addr[31:2], 2'b00}.
- data_sram_wdata  out  32  lane-aligned data of the head entry.
- ld_addr  in  32  address of a pending load.
- ld_hazard  out  1  some valid entry has word address == ld_addr[31:2].
- ades  out  1  one-cycle pulse: misaligned store was accepted in the previous cycle.
- badvaddr  out  32  address of the last misaligned store; held until the next one.
- sb_empty  out  1  buffer empty.

## Operation
- Accept when in_valid && in_ready.
- Push happens only if in_mode[4]=1 and the address is aligned.
- Non-store ops and misaligned stores are accepted and then dropped. They are never written to memory.
- Misalignment rules:
  - SH with addr[0]=1 is misaligned.
  - SW with addr[1:0]≠0 is misaligned.
  - SB, SWL and SWR are never misaligned.
  - Size code 101–111 is treated as a no-op store: no push, no ades.
- Lane generation, little-endian, a = addr[1:0]:
  - SB: wen = 4'b0001 << a; wdata = {4{rt[7:0]}}.
  - SH: wen = a[1] ? 1100 : 0011; wdata = {2{rt[15:0]}}.
  - SW: wen 1111; wdata rt.
  - SWL:
    - a=0: wen 0001, wdata {24'b0, rt[31:24]}
    - a=1: wen 0011, wdata {16'b0, rt[31:16]}
    - a=2: wen 0111, wdata {8'b0, rt[31:8]}
    - a=3: wen 1111, wdata rt
  - SWR:
    - a=0: wen 1111, wdata rt
    - a=1: wen 1110, wdata {rt[23:0], 8'b0}
    - a=2: wen 1100, wdata {rt[15:0], 16'b0}
    - a=3: wen 1000, wdata {rt[7:0], 24'b0}
- Lanes are computed at push. Each entry stores {addr[31:2], wen, wdata}.
- FIFO:
  - Read and write pointers are log2(DEPTH)+1 bits wide; their MSB disambiguates full from empty.
  - Wrap-around is modulo DEPTH.
  - Pop on data_sram_en && data_sram_ready.
  - A push and a pop in the same cycle leave count unchanged.
  - A push while full is impossible, because in_ready=0.
- Ordering: strictly FIFO. No merging, no reordering.
- ld_hazard: combinational compare against every valid entry. Entries popped this cycle still count. An entry pushed this cycle does not count until the next cycle.

## Timing
- Reset values:
  - pointers 0, count 0
  - data_sram_en 0, sb_empty 1, in_ready 1
  - ades 0, badvaddr 0, ld_hazard 0 (no valid entries)
  - wen, addr and wdata outputs are 0 while empty
- Latency: a store accepted in cycle N is visible at the SRAM port in cycle N+1 at the earliest. There is no combinational pass-through.
- Handshake: while data_sram_en=1 and data_sram_ready=0, data_sram_wen, data_sram_addr and data_sram_wdata are held stable.
- ades/badvaddr: registered, asserted in cycle N+1 for a misaligned store accepted in cycle N.
- Reset mid-operation clears all entries asynchronously. Queued stores are lost, and in_ready=1 immediately.
- in_ready depends only on registered count and has no combinational path from data_sram_ready.

## Structure
- Shared myCPU package holds:
  - size codes SZ_B=3'b000, SZ_H=3'b001, SZ_W=3'b010, SZ_L=3'b011, SZ_R=3'b100;
  - Mode bit indices MODE_LOAD=5, MODE_STORE=4.
- The writeback load extractor uses the same constants.
- One sub-module, mycpu_store_lanes: purely combinational (mode, a, rt) → (wen, wdata, misaligned).
- The top level holds the FIFO, the hazard compare and the ades register.

## Test plan
- SB, addr 0x1003, rt 0x12345678, ready=1 → next cycle wen 1000, addr 0x1000, wdata 0x78787878; popped; sb_empty=1.
- SWL at a=1 and SWR at a=1, rt 0xAABBCCDD:
  - SWL → wen 0011, wdata 0x0000AABB;
  - SWR → wen 1110, wdata 0xBBCCDD00.
- SW at 0x2002 → no SRAM request; ades=1 for one cycle; badvaddr 0x2002.
  - Then SH at 0x2001 → badvaddr 0x2001.
- Hold data_sram_ready=0 and push 3 stores with DEPTH=2 → in_ready=0 after the second. Outputs stay stable for 5 cycles.
  - Release ready → entries drain in order; third is accepted the cycle after the first pop.
- Buffered SW at 0x3004 with ready=0:
  - ld_addr 0x3006 → ld_hazard=1;
  - ld_addr 0x3008 → 0;
  - after drain → 0.
- Assert reset while 2 entries are queued → data_sram_en=0 and in_ready=1 immediately. No write reaches the SRAM after reset release.
